// File: rtl/fpmul_drv.sv
// fpmul_drv: requester-side controller for the fpmul Start/Done handshake.
//
// Takes operand pairs from an upstream valid/ready source and registers them
// onto A/B. It pulses Start for one cycle, then waits for Done. It captures
// P and the six status flags into a result register, which feeds a
// downstream valid/ready port. If Done does not arrive within TIMEOUT cycles,
// the operation is aborted and the driver reports a quiet NaN.
//
// Ports:
//   Clk, Rst              clock (rising edge), asynchronous active-low reset
//   In_Valid/In_Ready     upstream operand handshake
//   In_A, In_B            upstream operands (IEEE-754 single)
//   Start                 one-cycle start pulse to fpmul
//   A, B                  registered operands to fpmul
//   Done, P               fpmul completion pulse and product
//   UF..ZF                fpmul status flags
//   Out_Valid/Out_Ready   downstream result handshake
//   Out_P, Out_Flags      captured product and flags {UF,OF,NaNF,InfF,DNF,ZF}
//   Out_TO                result came from a timeout rather than Done
//   Op_Cnt                completed operations (wraps)
//   Spur_Cnt              Done pulses seen outside WAIT (saturates)
//   state_dbg             current FSM state (0=IDLE, 1=ISSUE, 2=WAIT)
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. The producer must hold valid and data stable
// until that edge. Ready may depend on the state but never on valid.
module fpmul_drv #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [31:0] In_A,
    input  logic [31:0] In_B,
    output logic        Start,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic        Done,
    input  logic [31:0] P,
    input  logic        UF,
    input  logic        OF,
    input  logic        NaNF,
    input  logic        InfF,
    input  logic        DNF,
    input  logic        ZF,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Out_P,
    output logic [5:0]  Out_Flags,
    output logic        Out_TO,
    output logic [15:0] Op_Cnt,
    output logic [7:0]  Spur_Cnt,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // The counter starts at 0 on the first WAIT cycle, so the comparison
    // against TIMEOUT-1 fires on the TIMEOUT-th WAIT cycle.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [1:0]    state;
    logic [CW-1:0] to_cnt;
    logic          accept;
    logic          in_wait;
    logic          timed_out;

    // The driver is only ready when idle and the result register is empty.
    // This means a capture can never overwrite an unread result. It is
    // gated by Rst so the upstream sees not-ready throughout reset.
    assign In_Ready  = Rst & (state == S_IDLE) & ~Out_Valid;
    assign accept    = In_Valid & In_Ready;
    assign Start     = (state == S_ISSUE);
    assign in_wait   = (state == S_WAIT);
    // Done has priority over the timeout when both occur in one cycle.
    assign timed_out = in_wait & ~Done & (to_cnt == TO_LAST);
    assign state_dbg = state;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= S_IDLE;
            to_cnt    <= '0;
            A         <= '0;
            B         <= '0;
            Out_Valid <= 1'b0;
            Out_P     <= '0;
            Out_Flags <= '0;
            Out_TO    <= 1'b0;
            Op_Cnt    <= '0;
            Spur_Cnt  <= '0;
        end else begin
            if (Out_Valid && Out_Ready) begin
                Out_Valid <= 1'b0;
            end

            // A Done outside WAIT has no operation to belong to. This
            // includes a late Done after a timeout.
            if (Done && !in_wait && (Spur_Cnt != 8'hFF)) begin
                Spur_Cnt <= Spur_Cnt + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        A     <= In_A;
                        B     <= In_B;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    to_cnt <= to_cnt + CW'(1);
                    if (Done) begin
                        Out_P     <= P;
                        Out_Flags <= {UF, OF, NaNF, InfF, DNF, ZF};
                        Out_TO    <= 1'b0;
                        Out_Valid <= 1'b1;
                        Op_Cnt    <= Op_Cnt + 16'd1;
                        state     <= S_IDLE;
                    end else if (timed_out) begin
                        Out_P     <= QNAN;
                        Out_Flags <= 6'b001000;
                        Out_TO    <= 1'b1;
                        Out_Valid <= 1'b1;
                        Op_Cnt    <= Op_Cnt + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_drv.sv
// tb_fpmul_drv: directed bench for fpmul_drv with TIMEOUT=8.
//
// Inputs change 1 time unit after the rising edge. Outputs are checked on
// the falling edge against a cycle model. The model tracks each operation
// as "cycles since accept" and applies the handshake rules to that count.
// Results leaving the downstream port are also checked against a queue of
// hand-computed values.
module tb_fpmul_drv;

    localparam int TO = 8;

    logic        Clk;
    logic        Rst;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] In_A;
    logic [31:0] In_B;
    logic        Start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Done;
    logic [31:0] P;
    logic [5:0]  fl_in;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_P;
    logic [5:0]  Out_Flags;
    logic        Out_TO;
    logic [15:0] Op_Cnt;
    logic [7:0]  Spur_Cnt;
    logic [1:0]  state_dbg;

    fpmul_drv #(.TIMEOUT(TO), .CW(8)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .In_A      (In_A),
        .In_B      (In_B),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .Done      (Done),
        .P         (P),
        .UF        (fl_in[5]),
        .OF        (fl_in[4]),
        .NaNF      (fl_in[3]),
        .InfF      (fl_in[2]),
        .DNF       (fl_in[1]),
        .ZF        (fl_in[0]),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_P     (Out_P),
        .Out_Flags (Out_Flags),
        .Out_TO    (Out_TO),
        .Op_Cnt    (Op_Cnt),
        .Spur_Cnt  (Spur_Cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total;
    int bad;
    int start_cnt;

    // result scoreboard: {to, flags, p}
    logic [38:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- reference model + compare process ----------------
    int          m_since;    // -1: no op in flight; else cycles since accept
    logic [31:0] e_a, e_b, e_p;
    logic [5:0]  e_fl;
    logic        e_to, e_ov;
    logic [15:0] e_op;
    logic [7:0]  e_spur;
    logic        e_in_ready, e_start;

    task automatic model_reset();
        m_since = -1;
        e_a = 0; e_b = 0; e_p = 0; e_fl = 0; e_to = 0; e_ov = 0;
        e_op = 0; e_spur = 0;
    endtask

    initial begin
        logic acc, waiting, fin;
        logic [38:0] front;
        model_reset();
        forever begin
            @(negedge Clk);
            if (!Rst) model_reset();
            e_in_ready = Rst && (m_since < 0) && !e_ov;
            e_start    = (m_since == 1);

            chk("in_ready", In_Ready, e_in_ready);
            chk("start", Start, e_start);
            chk("a", A, e_a);
            chk("b", B, e_b);
            chk("out_valid", Out_Valid, e_ov);
            chk("out_p", Out_P, e_p);
            chk("out_flags", Out_Flags, e_fl);
            chk("out_to", Out_TO, e_to);
            chk("op_cnt", Op_Cnt, e_op);
            chk("spur_cnt", Spur_Cnt, e_spur);
            if (Start) start_cnt++;

            // downstream transfer: compare against the hand-computed queue
            if (Rst && Out_Valid && Out_Ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_result", 1, 0);
                end else begin
                    front = exp_q.pop_front();
                    chk("sb_result", {Out_TO, Out_Flags, Out_P}, front);
                end
            end

            // advance the model with the inputs present during this cycle
            if (Rst) begin
                acc     = e_in_ready && In_Valid;
                waiting = (m_since >= 2);
                fin     = 1'b0;
                if (e_ov && Out_Ready) e_ov = 1'b0;
                if (waiting && Done) begin
                    e_p = P; e_fl = fl_in; e_to = 1'b0; e_ov = 1'b1; fin = 1'b1;
                end else if (waiting && (m_since - 2 == TO - 1)) begin
                    e_p = 32'h7FC00000; e_fl = 6'b001000; e_to = 1'b1; e_ov = 1'b1; fin = 1'b1;
                end
                if (fin) e_op = e_op + 16'd1;
                if (Done && !waiting && e_spur != 8'hFF) e_spur = e_spur + 8'd1;
                if (acc) begin
                    e_a = In_A;
                    e_b = In_B;
                end
                if (fin) m_since = -1;
                else if (m_since >= 1) m_since = m_since + 1;
                else if (acc) m_since = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present a pair and hold it until accepted. Returns in the Start cycle.
    task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
        int n;
        In_A = a;
        In_B = b;
        In_Valid = 1'b1;
        n = 0;
        while (!In_Ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 1, 0);
        tick();
        In_Valid = 1'b0;
        chk("start_after_accept", Start, 1);
    endtask

    // Pulse Done 'delay' cycles after the Start cycle; returns one cycle later.
    task automatic pulse_done(input int delay, input logic [31:0] p, input logic [5:0] fl);
        repeat (delay) tick();
        Done = 1'b1;
        P = p;
        fl_in = fl;
        tick();
        Done = 1'b0;
        fl_in = 6'b0;
        chk("out_valid_at_done_plus1", Out_Valid, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s0;
        total = 0; bad = 0; start_cnt = 0;
        Rst = 1'b0; In_Valid = 1'b0; In_A = 0; In_B = 0;
        Done = 1'b0; P = 0; fl_in = 0; Out_Ready = 1'b1;

        // reset state
        tick();
        chk("rst_in_ready", In_Ready, 0);
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_op_cnt", Op_Cnt, 0);
        chk("rst_a", A, 0);
        tick();
        Rst = 1'b1;
        tick();
        chk("idle_in_ready", In_Ready, 1);

        // basic op: 2.0 * 3.0, Done 5 cycles after Start
        s0 = start_cnt;
        exp_q.push_back({1'b0, 6'b000000, 32'h40C00000});
        send_pair(32'h40000000, 32'h40400000);
        pulse_done(5, 32'h40C00000, 6'b000000);
        chk("basic_out_p", Out_P, 32'h40C00000);
        chk("basic_flags", Out_Flags, 0);
        chk("basic_to", Out_TO, 0);
        chk("basic_op_cnt", Op_Cnt, 1);
        tick();
        chk("basic_valid_drop", Out_Valid, 0);
        chk("basic_in_ready_back", In_Ready, 1);
        chk("basic_one_start", start_cnt - s0, 1);

        // flags passthrough: overflow to infinity
        exp_q.push_back({1'b0, 6'b010100, 32'h7F800000});
        send_pair(32'h7F000000, 32'h7F000000);
        pulse_done(3, 32'h7F800000, 6'b010100);
        chk("flags_out", Out_Flags, 6'b010100);
        chk("flags_op_cnt", Op_Cnt, 2);
        tick();

        // backpressure: result 1 held while a second pair waits
        Out_Ready = 1'b0;
        exp_q.push_back({1'b0, 6'b000000, 32'h40800000});
        exp_q.push_back({1'b0, 6'b000000, 32'hC0C00000});
        send_pair(32'h3F800000, 32'h40800000);
        pulse_done(3, 32'h40800000, 6'b000000);
        In_A = 32'hC0000000;
        In_B = 32'h40400000;
        In_Valid = 1'b1;
        s0 = start_cnt;
        repeat (6) begin
            tick();
            chk("bp_in_ready_low", In_Ready, 0);
        end
        chk("bp_no_start", start_cnt - s0, 0);
        chk("bp_held_p", Out_P, 32'h40800000);
        Out_Ready = 1'b1;
        tick();
        tick();
        chk("bp_start_2_after_drain", Start, 1);
        In_Valid = 1'b0;
        pulse_done(4, 32'hC0C00000, 6'b000000);
        chk("bp_op_cnt", Op_Cnt, 4);
        tick();

        // timeout: Done never comes
        Out_Ready = 1'b0;
        exp_q.push_back({1'b1, 6'b001000, 32'h7FC00000});
        send_pair(32'h3F800000, 32'h3F800000);
        repeat (TO) tick();
        chk("to_not_yet", Out_Valid, 0);
        tick();
        chk("to_valid", Out_Valid, 1);
        chk("to_flag", Out_TO, 1);
        chk("to_p", Out_P, 32'h7FC00000);
        chk("to_flags", Out_Flags, 6'b001000);
        Done = 1'b1;
        P = 32'h12345678;
        fl_in = 6'b111111;
        tick();
        Done = 1'b0;
        fl_in = 0;
        tick();
        chk("late_done_spur", Spur_Cnt, 1);
        chk("late_done_p_kept", Out_P, 32'h7FC00000);
        chk("to_op_cnt", Op_Cnt, 5);
        Out_Ready = 1'b1;
        tick();
        tick();

        // Done on the timeout cycle: Done wins
        exp_q.push_back({1'b0, 6'b000000, 32'h41A00000});
        send_pair(32'h40800000, 32'h40A00000);
        pulse_done(TO, 32'h41A00000, 6'b000000);
        chk("tie_to", Out_TO, 0);
        chk("tie_p", Out_P, 32'h41A00000);
        tick();

        // reset in the middle of WAIT
        send_pair(32'h3F800000, 32'h3F800000);
        tick();
        tick();
        Rst = 1'b0;
        #1;
        chk("mid_rst_start", Start, 0);
        chk("mid_rst_valid", Out_Valid, 0);
        chk("mid_rst_op_cnt", Op_Cnt, 0);
        chk("mid_rst_spur", Spur_Cnt, 0);
        chk("mid_rst_in_ready", In_Ready, 0);
        tick();
        Rst = 1'b1;
        tick();
        Done = 1'b1;
        P = 32'h3F800000;
        tick();
        Done = 1'b0;
        tick();
        chk("post_rst_valid", Out_Valid, 0);
        chk("post_rst_spur", Spur_Cnt, 1);

        // recovery: 1.5 * 2.0
        exp_q.push_back({1'b0, 6'b000000, 32'h40400000});
        send_pair(32'h3FC00000, 32'h40000000);
        pulse_done(2, 32'h40400000, 6'b000000);
        chk("recover_op_cnt", Op_Cnt, 1);
        tick();
        tick();

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpmul_drv.md
Name: fpmul_drv

Overview:
- Requester-side controller for the fpmul Start/Done handshake.
- Accepts operand pairs from an upstream valid/ready source and registers A/B.
- Pulses Start to the multiplier, waits for Done, then captures P and the six status flags into a result register presented on a downstream valid/ready port.
- Adds a Done timeout, a spurious-Done counter and a completed-operation counter for system integration and debug.

Parameters:
- TIMEOUT, 64, cycles in WAIT without Done before the op is aborted; legal range 2..2^CW-1.
- CW, 8, width of the timeout counter.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  asynchronous reset, active-low.
- In_Valid  in  1  upstream operand pair valid.
- In_Ready  out  1  driver can accept an operand pair.
- In_A  in  32  operand A, IEEE-754 single.
- In_B  in  32  operand B, IEEE-754 single.
- Start  out  1  one-cycle start pulse to fpmul.
- A  out  32  registered operand A to fpmul.
- B  out  32  registered operand B to fpmul.
- Done  in  1  fpmul completion pulse.
- P  in  32  fpmul product.
- UF, OF, NaNF, InfF, DNF, ZF  in  1 each  fpmul status flags.
- Out_Valid  out  1  result register full.
- Out_Ready  in  1  downstream accepts result.
- Out_P  out  32  captured product.
- Out_Flags  out  6  captured flags {UF,OF,NaNF,InfF,DNF,ZF}.
- Out_TO  out  1  result produced by timeout, not by Done.
- Op_Cnt  out  16  completed ops (Done or timeout); wraps 0xFFFF->0.
- Spur_Cnt  out  8  Done pulses seen outside WAIT; saturates at 0xFF.

Behaviour:
- Reset (Rst=0, async):
  - State=IDLE.
  - Start=0, A=B=0.
  - Out_Valid=0, Out_P=0, Out_Flags=0, Out_TO=0.
  - Op_Cnt=0, Spur_Cnt=0, timeout counter=0.
  - In_Ready=0 while Rst=0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - In_Ready = ~Out_Valid (combinational).
  - In_Valid & In_Ready: latch In_A/In_B into A/B, go to ISSUE.
- ISSUE: Start=1 for exactly this cycle; clear timeout counter; go to WAIT.
- WAIT:
  - Start=0; timeout counter increments each cycle.
  - Done=1: capture P -> Out_P, flags -> Out_Flags; Out_TO=0; Out_Valid=1; Op_Cnt+1; go to IDLE.
  - Done=0 and counter reaches TIMEOUT-1: Out_P=0x7FC00000; Out_Flags=6'b001000 (NaNF only); Out_TO=1; Out_Valid=1; Op_Cnt+1; go to IDLE.
  - Done and timeout in the same cycle: Done wins; Out_TO=0.
- A and B hold stable from the ISSUE cycle until the next accepted operand. The fpmul may sample them at any point during WAIT.
- Result register:
  - Out_Valid clears on Out_Valid & Out_Ready.
  - Out_P, Out_Flags and Out_TO hold until the next capture.
  - Out_Valid never overwrites itself: In_Ready requires Out_Valid=0, so the register is empty when Done arrives.
- Latency:
  - Accept at cycle 0, Start at cycle 1, WAIT from cycle 2.
  - Done at cycle k gives Out_Valid=1 at cycle k+1.
  - With Out_Ready held 1: Out_Valid drops at k+2, and In_Ready returns at k+2.
- Spurious Done (Done=1 in IDLE or ISSUE): ignored for data; Spur_Cnt+1, saturating at 0xFF. A late Done after a timeout counts here.
- Reset mid-operation (any state) returns to the reset values above. A subsequent Done is counted as spurious.
- In_Valid with In_Ready=0 has no effect; the upstream must hold its data.

Test Plan:
- Basic op:
  - Stimulus: In_A=0x40000000 (2.0), In_B=0x40400000 (3.0); model returns P=0x40C00000 with Done 5 cycles after Start.
  - Required: exactly one Start pulse; Out_Valid at Done+1; Out_P=0x40C00000; Out_Flags=0; Out_TO=0; Op_Cnt=1.
- Flags passthrough:
  - Stimulus: model returns P=0x7F800000, OF=1, InfF=1.
  - Required: Out_Flags=6'b010100.
- Backpressure:
  - Stimulus: Out_Ready=0 after result 1; In_Valid held high with a second pair.
  - Required: In_Ready=0 and no second Start until Out_Ready=1 drains result 1; Start then follows 2 cycles later.
- Timeout, TIMEOUT=8:
  - Stimulus: model never asserts Done.
  - Required: Out_Valid exactly 8 cycles after entering WAIT; Out_P=0x7FC00000; Out_Flags=6'b001000; Out_TO=1.
  - Follow-up: a late Done then gives Spur_Cnt=1 and Out_P unchanged.
- Done on the timeout cycle:
  - Stimulus: Done coincides with counter=TIMEOUT-1.
  - Required: Out_TO=0; Out_P=model P.
- Reset mid-WAIT:
  - Stimulus: Rst=0 for 1 cycle during WAIT.
  - Required: immediately Start=0, Out_Valid=0, counters 0. After release, a Done pulse leaves Out_Valid=0 and sets Spur_Cnt=1.
